// File: rtl/bp_initiator_pkg.sv
// Shared types for the bus initiator: FSM state encoding and the captured response.
package bp_initiator_pkg;

    localparam int BP_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } bp_init_state_t;

    typedef struct packed {
        logic [BP_DATA_WIDTH-1:0] rdata;
        logic                     error;
        logic                     timeout;
    } bp_init_rsp_t;

endpackage

// File: rtl/bp_initiator_if.sv
// Command/response handshake port of the bus initiator; master issues commands, slave executes them.
interface bp_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [DATA_WIDTH/8-1:0] cmd_strobe;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_error;
    logic                    rsp_timeout;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strobe, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout
    );
endinterface

// File: rtl/bus_protocol_if.sv
// Generic single-transfer bus between an initiator and a peripheral, plus constant burst/security hints.
interface bus_protocol_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wen;
    logic                    ren;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] strobe;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;
    logic                    request_stall;
    logic                    is_burst;
    logic [1:0]              burst_type;
    logic [7:0]              burst_length;
    logic                    secure_transfer;

    modport protocol (
        output wen, ren, addr, wdata, strobe,
               is_burst, burst_type, burst_length, secure_transfer,
        input  rdata, error, request_stall
    );

    modport peripheral (
        input  wen, ren, addr, wdata, strobe,
               is_burst, burst_type, burst_length, secure_transfer,
        output rdata, error, request_stall
    );
endinterface

// File: rtl/bp_stall_timer.sv
// Saturating stall counter; expired flags the last permitted stalled cycle of a transaction.
module bp_stall_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic nReset,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (stall && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

    // A zero TIMEOUT disables the guard entirely; the counter is then left dangling.
    generate
        if (TIMEOUT == 0) begin : g_no_guard
            assign expired = 1'b0;
        end else begin : g_guard
            assign expired = stall && (count == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/bp_initiator.sv
// Single-outstanding bus initiator: turns one command into one bus transaction and returns its response.
module bp_initiator
    import bp_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = BP_DATA_WIDTH,
    parameter int TIMEOUT    = 256
) (
    input logic              clk,
    input logic              nReset,
    bp_initiator_if.slave    cmd,
    bus_protocol_if.protocol bp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    bp_init_state_t state;
    bp_init_rsp_t   rsp_q;
    logic           accept;
    logic           expired;

    assign accept = (state == IDLE) && cmd.cmd_valid;

    bp_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk     (clk),
        .nReset  (nReset),
        .clear   (accept),
        .stall   ((state == BUSY) && bp.request_stall),
        .expired (expired)
    );

    assign cmd.cmd_ready   = (state == IDLE);
    assign cmd.rsp_valid   = (state == RESP);
    assign cmd.rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
    assign cmd.rsp_error   = rsp_q.error;
    assign cmd.rsp_timeout = rsp_q.timeout;

    assign bp.is_burst        = 1'b0;
    assign bp.burst_type      = 2'b00;
    assign bp.burst_length    = 8'd0;
    assign bp.secure_transfer = 1'b0;

    // Completion is tested before the timeout so a final non-stalled cycle always wins.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            bp.wen        <= 1'b0;
            bp.ren        <= 1'b0;
            bp.addr       <= '0;
            bp.wdata      <= '0;
            bp.strobe     <= '0;
            rsp_q         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        bp.addr   <= ADDR_WIDTH'(cmd.cmd_addr);
                        bp.wdata  <= cmd.cmd_wdata;
                        bp.strobe <= cmd.cmd_write ? cmd.cmd_strobe : {STRB_WIDTH{1'b1}};
                        bp.wen    <= cmd.cmd_write;
                        bp.ren    <= !cmd.cmd_write;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bp.request_stall) begin
                        rsp_q.rdata   <= bp.ren ? BP_DATA_WIDTH'(bp.rdata) : '0;
                        rsp_q.error   <= bp.error;
                        rsp_q.timeout <= 1'b0;
                        bp.wen        <= 1'b0;
                        bp.ren        <= 1'b0;
                        state         <= RESP;
                    end else if (expired) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.error   <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        bp.wen        <= 1'b0;
                        bp.ren        <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (cmd.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bp_initiator.md
# bp_initiator

Bus initiator for `bus_protocol_if`. Takes single read/write commands on a valid/ready port, runs each one as one transaction on the `protocol` modport, and returns rdata and error status on a valid/ready response port. It is the master-side counterpart to peripherals such as `AHBUart`. Typical uses are firmware-less bring-up sequencers and bench/DMA front ends. A stall-timeout guard stops a hung peripheral from locking up the initiator.

## Interface
- `ADDR_WIDTH`, 32: bus address width; must match the interface.
- `DATA_WIDTH`, 32: bus data width; must be a multiple of 8.
- `TIMEOUT`, 256: maximum stalled cycles per transaction; 0 disables the guard.
- `clk`  in  1  system clock; one clock domain; everything is rising-edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  offset address.
- `cmd_wdata`  in  DATA_WIDTH  write data.
- `cmd_strobe`  in  DATA_WIDTH/8  byte enables; used for writes only.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed on `rsp_valid & rsp_ready`.
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- `rsp_error`  out  1  the peripheral raised `error`, or a timeout occurred.
- `rsp_timeout`  out  1  the transaction was aborted by the stall guard.
- `bp`  interface  `bus_protocol_if.protocol`  drives the vital and hint signals.

## Operation
- FSM states are IDLE, BUSY and RESP. The reset state is IDLE.
- `cmd_ready` = (state == IDLE). It reads 1 while in reset.
- **IDLE, on accept:** register `addr`, `wdata` and `write` into the bus registers. Set `wen = cmd_write` and `ren = ~cmd_write`. Set `strobe = cmd_strobe` for writes and all-ones for reads. Clear the stall counter. Go to BUSY.
- **BUSY:** hold all bus outputs stable.
- **BUSY, completion** (`request_stall == 0` in a BUSY cycle):
  - Capture `rdata` (reads only; 0 for writes) and `error`.
  - Clear `wen`/`ren`. Go to RESP.
- **BUSY, stall** (`request_stall == 1`): increment the counter.
- **BUSY, timeout:** if `TIMEOUT != 0`, the counter equals `TIMEOUT-1` and `request_stall` is still 1:
  - Clear `wen`/`ren`.
  - Set `rsp_error = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`. Go to RESP.
- **RESP:** `rsp_valid = 1`. Response fields stay stable until `rsp_ready`, then go to IDLE. Response fields keep their value afterwards; they are only meaningful while `rsp_valid` is high.
- Completion and timeout in the same cycle: completion wins because `request_stall` is 0.
- Hint outputs are constant: `is_burst = 0`, `burst_type = 0`, `burst_length = 0`, `secure_transfer = 0`.
- The stall counter is `$clog2(TIMEOUT+1)` bits wide and saturates. It is never compared when `TIMEOUT == 0`.
- Only one transaction is in flight. There is no queueing.

## Timing
- **Reset values:** `wen`, `ren`, `addr`, `wdata`, `strobe`, `rsp_valid`, `rsp_rdata`, `rsp_error`, `rsp_timeout` are all 0. `cmd_ready` is 1.
- **Reset asserted mid-transaction:** bus strobes drop asynchronously. The transaction is abandoned, no response is produced, and the FSM returns to IDLE.
- **Bus outputs:** all registered. `wen`/`ren` rise in the cycle after the accept edge (cycle A+1).
- **Zero-stall latency:** completes in cycle A+1. `rsp_valid` is high in cycle A+2.
- **Stalled latency:** with S stall cycles, `rsp_valid` rises in cycle A+2+S.
- **Timeout latency:** `rsp_valid` rises in cycle A+1+TIMEOUT.
- **Back-to-back:** the minimum command period is 3 cycles (accept, bus, response with `rsp_ready` = 1). The next accept can happen in the cycle after the response handshake.

## Structure
- **Package `bp_initiator_pkg`:**
  - state enum typedef `bp_init_state_t` (IDLE, BUSY, RESP);
  - response struct `bp_init_rsp_t` (rdata, error, timeout).
- **Sub-module `bp_stall_timer`:**
  - parameter TIMEOUT;
  - inputs `clear`, `stall`;
  - output `expired`;
  - ties `expired` to 0 when TIMEOUT = 0.

## Test plan
- **Write, no stall:** write to addr 24, data 0x0F, strobe 0xF, `request_stall` = 0.
  - `wen` = 1 for exactly one cycle with addr 24 and data 0x0F.
  - `rsp_valid` in cycle A+2 with error 0 and rdata 0.
- **Read, stalled:** read addr 0x10 while the peripheral stalls 3 cycles, then returns 0xDEADBEEF.
  - `ren` is held for 4 cycles and `strobe` = 0xF.
  - `rsp_rdata` = 0xDEADBEEF in cycle A+5.
- **Peripheral error:** read with `error` = 1 at completion.
  - `rsp_error` = 1, `rsp_timeout` = 0.
- **Timeout:** TIMEOUT = 8, `request_stall` held at 1.
  - `ren` drops after 8 bus cycles.
  - `rsp_error` = 1, `rsp_timeout` = 1, rdata 0, `rsp_valid` in cycle A+9.
- **Response backpressure:** `rsp_ready` = 0 for 5 cycles.
  - `rsp_valid` and data stay stable; `cmd_ready` stays 0.
  - A second command is accepted in the cycle after the handshake.
- **Reset in BUSY:** drop `nReset` during a stall.
  - `wen`/`ren` go to 0 immediately and no response is produced.
  - After reset, a new write completes normally.
